// File: rtl/collision_life_fsm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : collision_pkg
//  Description : State encoding and default game constants shared by the
//                collision/life FSM and the score/HUD block.
//  Revision    : 1.0 - initial release
// ============================================================================
package collision_pkg;

    // Game-level states with an explicit 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_HIT  = 2'b10,
        ST_OVER = 2'b11
    } state_t;

    // Defaults shared with the HUD so both blocks agree on the game rules
    localparam int DEF_LIVES_INIT    = 3;
    localparam int DEF_CONFIRM_TICKS = 2;
    localparam int DEF_HIT_FRAMES    = 30;

endpackage
`default_nettype wire

// File: rtl/collision_life_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module      : collision_life_fsm_if
//  Description : Game-control bundle between the collision/life FSM and its
//                neighbours (frame timing, collision mux, frog/lane logic).
//  Revision    : 1.0 - initial release
// ============================================================================
interface collision_life_fsm_if #(
    parameter int LIVES_WIDTH = 2
);
    logic                   CollisionLife_FrameTick_In;
    logic                   CollisionLife_Collision_In;
    logic                   CollisionLife_Start_In;
    logic [LIVES_WIDTH-1:0] CollisionLife_Lives_Out;
    logic                   CollisionLife_Freeze_Out;
    logic                   CollisionLife_Respawn_Out;
    logic                   CollisionLife_Hit_Out;
    logic                   CollisionLife_GameOver_Out;

    // Driver side: produces ticks, collision and start, observes game state
    modport master (
        output CollisionLife_FrameTick_In,
        output CollisionLife_Collision_In,
        output CollisionLife_Start_In,
        input  CollisionLife_Lives_Out,
        input  CollisionLife_Freeze_Out,
        input  CollisionLife_Respawn_Out,
        input  CollisionLife_Hit_Out,
        input  CollisionLife_GameOver_Out
    );

    // FSM side
    modport slave (
        input  CollisionLife_FrameTick_In,
        input  CollisionLife_Collision_In,
        input  CollisionLife_Start_In,
        output CollisionLife_Lives_Out,
        output CollisionLife_Freeze_Out,
        output CollisionLife_Respawn_Out,
        output CollisionLife_Hit_Out,
        output CollisionLife_GameOver_Out
    );
endinterface
`default_nettype wire

// File: rtl/collision_life_fsm_tick_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tick_counter
//  Description : Clearable up-counter with tick enable. o_terminal flags the
//                tick that brings the count to LIMIT, so the owner can act
//                on the very next clock and clear the counter at that point.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_counter #(
    parameter int CNT_WIDTH = 6,
    parameter int LIMIT     = 2
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_clear,
    input  wire logic i_tick,
    output logic      o_terminal
);

    localparam logic [CNT_WIDTH-1:0] c_last = CNT_WIDTH'(LIMIT - 1);

    logic [CNT_WIDTH-1:0] r_count;

    // Clear has priority; the count holds at LIMIT rather than wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_tick && (r_count <= c_last)) begin
            r_count <= r_count + CNT_WIDTH'(1);
        end
    end

    assign o_terminal = i_tick && (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/collision_life_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : collision_life_fsm
//  Description : Turns the frame-sampled collision bit into confirmed hits,
//                freeze periods, life loss, respawn requests and game over.
//  Revision    : 1.0 - initial release
// ============================================================================
module collision_life_fsm
    import collision_pkg::*;
#(
    parameter int LIVES_INIT    = DEF_LIVES_INIT,
    parameter int LIVES_WIDTH   = 2,
    parameter int CONFIRM_TICKS = DEF_CONFIRM_TICKS,
    parameter int HIT_FRAMES    = DEF_HIT_FRAMES,
    parameter int CNT_WIDTH     = 6
) (
    input  wire logic             CLOCK_50,
    input  wire logic             RESET_InLow,
    collision_life_fsm_if.slave   bus
);

    localparam logic [LIVES_WIDTH-1:0] c_lives_init = LIVES_WIDTH'(LIVES_INIT);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [LIVES_WIDTH-1:0]  r_lives;
    logic [LIVES_WIDTH-1:0]  w_lives_nxt;
    logic                    r_freeze;
    logic                    w_freeze_nxt;
    logic                    r_respawn;
    logic                    w_respawn_nxt;
    logic                    r_hit;
    logic                    w_hit_nxt;
    logic                    r_game_over;
    logic                    w_game_over_nxt;

    logic w_tick;
    logic w_coll;
    logic w_start;
    logic w_in_play;
    logic w_in_hit;
    logic w_confirm_tick;
    logic w_confirm_clear;
    logic w_confirm_done;
    logic w_hit_tick;
    logic w_hit_clear;
    logic w_hit_done;

    assign w_tick    = bus.CollisionLife_FrameTick_In;
    assign w_coll    = bus.CollisionLife_Collision_In;
    assign w_start   = bus.CollisionLife_Start_In;
    assign w_in_play = (r_state == ST_PLAY);
    assign w_in_hit  = (r_state == ST_HIT);

    // Confirm counter: counts consecutive colliding ticks while playing; held
    // at zero in every other state so PLAY is always entered with a fresh count
    assign w_confirm_tick  = w_in_play && w_tick && w_coll;
    assign w_confirm_clear = !w_in_play || (w_tick && !w_coll) || w_confirm_done;

    // Hit-frame counter: only runs in HIT, zero on entry
    assign w_hit_tick  = w_in_hit && w_tick;
    assign w_hit_clear = !w_in_hit || w_hit_done;

    tick_counter #(
        .CNT_WIDTH (CNT_WIDTH),
        .LIMIT     (CONFIRM_TICKS)
    ) u_confirm_cnt (
        .clk        (CLOCK_50),
        .rst_n      (RESET_InLow),
        .i_clear    (w_confirm_clear),
        .i_tick     (w_confirm_tick),
        .o_terminal (w_confirm_done)
    );

    tick_counter #(
        .CNT_WIDTH (CNT_WIDTH),
        .LIMIT     (HIT_FRAMES)
    ) u_hit_cnt (
        .clk        (CLOCK_50),
        .rst_n      (RESET_InLow),
        .i_clear    (w_hit_clear),
        .i_tick     (w_hit_tick),
        .o_terminal (w_hit_done)
    );

    // State and all outputs registered together; reset leaves the game idle
    always_ff @(posedge CLOCK_50 or negedge RESET_InLow) begin
        if (!RESET_InLow) begin
            r_state     <= ST_IDLE;
            r_lives     <= c_lives_init;
            r_freeze    <= 1'b1;
            r_respawn   <= 1'b0;
            r_hit       <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_lives     <= w_lives_nxt;
            r_freeze    <= w_freeze_nxt;
            r_respawn   <= w_respawn_nxt;
            r_hit       <= w_hit_nxt;
            r_game_over <= w_game_over_nxt;
        end
    end

    // Next state and next output values; respawn defaults low so it can only
    // ever be a single-cycle pulse on a transition into PLAY
    always_comb begin
        w_state_nxt     = r_state;
        w_lives_nxt     = r_lives;
        w_freeze_nxt    = r_freeze;
        w_respawn_nxt   = 1'b0;
        w_hit_nxt       = r_hit;
        w_game_over_nxt = r_game_over;
        case (r_state)
            ST_IDLE, ST_OVER: begin
                // Start wins over a coincident tick; that tick is not sampled
                if (w_start) begin
                    w_state_nxt     = ST_PLAY;
                    w_lives_nxt     = c_lives_init;
                    w_freeze_nxt    = 1'b0;
                    w_respawn_nxt   = 1'b1;
                    w_hit_nxt       = 1'b0;
                    w_game_over_nxt = 1'b0;
                end else begin
                    w_freeze_nxt    = 1'b1;
                    w_hit_nxt       = 1'b0;
                    w_game_over_nxt = (r_state == ST_OVER);
                end
            end
            ST_PLAY: begin
                w_freeze_nxt = 1'b0;
                if (w_confirm_done) begin
                    w_state_nxt  = ST_HIT;
                    w_hit_nxt    = 1'b1;
                    w_freeze_nxt = 1'b1;
                    w_lives_nxt  = (r_lives == '0) ? '0 : r_lives - LIVES_WIDTH'(1);
                end
            end
            ST_HIT: begin
                w_freeze_nxt = 1'b1;
                w_hit_nxt    = 1'b1;
                if (w_hit_done) begin
                    w_hit_nxt = 1'b0;
                    if (r_lives == '0) begin
                        w_state_nxt     = ST_OVER;
                        w_game_over_nxt = 1'b1;
                    end else begin
                        w_state_nxt   = ST_PLAY;
                        w_freeze_nxt  = 1'b0;
                        w_respawn_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_freeze_nxt = 1'b1;
            end
        endcase
    end

    assign bus.CollisionLife_Lives_Out    = r_lives;
    assign bus.CollisionLife_Freeze_Out   = r_freeze;
    assign bus.CollisionLife_Respawn_Out  = r_respawn;
    assign bus.CollisionLife_Hit_Out      = r_hit;
    assign bus.CollisionLife_GameOver_Out = r_game_over;

endmodule
`default_nettype wire

// File: tb/tb_collision_life_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_collision_life_fsm
//  Description : Self-checking bench for collision_life_fsm: directed vector
//                table, hand-written corner sequences, and randomized play
//                against a rule-level model of the game.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_collision_life_fsm;

    localparam int c_lives_init = 3;
    localparam int c_confirm    = 2;
    localparam int c_hit_frames = 4;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    collision_life_fsm_if #(.LIVES_WIDTH(2)) bus ();

    collision_life_fsm #(
        .LIVES_INIT    (c_lives_init),
        .LIVES_WIDTH   (2),
        .CONFIRM_TICKS (c_confirm),
        .HIT_FRAMES    (c_hit_frames),
        .CNT_WIDTH     (6)
    ) u_dut (
        .CLOCK_50    (clk),
        .RESET_InLow (rst_n),
        .bus         (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       tick;
        logic       coll;
        logic       start;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl[19];

    // Packs expected outputs as {lives, freeze, respawn, hit, game_over}
    function automatic logic [5:0] pk(input int l, input logic f, input logic r,
                                      input logic h, input logic g);
        logic [31:0] lv;
        lv = l;
        return {lv[1:0], f, r, h, g};
    endfunction

    task automatic check(input string nm, input logic [5:0] exp);
        logic [5:0] act;
        act = {bus.CollisionLife_Lives_Out, bus.CollisionLife_Freeze_Out,
               bus.CollisionLife_Respawn_Out, bus.CollisionLife_Hit_Out,
               bus.CollisionLife_GameOver_Out};
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual {lives,frz,rsp,hit,go}=%b required=%b at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, then sample 1ns after the rising edge
    task automatic step(input logic t, input logic c, input logic s);
        bus.CollisionLife_FrameTick_In = t;
        bus.CollisionLife_Collision_In = c;
        bus.CollisionLife_Start_In     = s;
        @(posedge clk);
        #1;
    endtask

    // Rule-level reference: whether the game is running, frozen after a hit,
    // or over, plus counts of the current collision streak and frozen frames
    bit m_run, m_inhit, m_over, m_resp;
    int m_lives, m_streak, m_frames;

    task automatic model_reset();
        m_run = 0; m_inhit = 0; m_over = 0; m_resp = 0;
        m_lives = c_lives_init; m_streak = 0; m_frames = 0;
    endtask

    task automatic model_step(input bit t, input bit c, input bit s);
        m_resp = 0;
        if (m_inhit) begin
            if (t) begin
                m_frames++;
                if (m_frames == c_hit_frames) begin
                    m_inhit = 0;
                    if (m_lives == 0) m_over = 1;
                    else begin m_run = 1; m_resp = 1; end
                end
            end
        end else if (m_run) begin
            if (t) begin
                if (c) begin
                    m_streak++;
                    if (m_streak == c_confirm) begin
                        m_lives  = (m_lives > 0) ? m_lives - 1 : 0;
                        m_run    = 0;
                        m_inhit  = 1;
                        m_frames = 0;
                        m_streak = 0;
                    end
                end else begin
                    m_streak = 0;
                end
            end
        end else if (s) begin
            m_run = 1; m_over = 0; m_lives = c_lives_init; m_streak = 0; m_resp = 1;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.CollisionLife_FrameTick_In = 1'b0;
        bus.CollisionLife_Collision_In = 1'b0;
        bus.CollisionLife_Start_In     = 1'b0;

        // {tick, coll, start} -> outputs after the next edge
        tbl[0]  = '{1'b0, 1'b0, 1'b0, pk(3, 1, 0, 0, 0)}; // idle
        tbl[1]  = '{1'b1, 1'b1, 1'b0, pk(3, 1, 0, 0, 0)}; // tick ignored in idle
        tbl[2]  = '{1'b0, 1'b0, 1'b1, pk(3, 0, 1, 0, 0)}; // start -> play, respawn
        tbl[3]  = '{1'b0, 1'b0, 1'b0, pk(3, 0, 0, 0, 0)}; // respawn one cycle only
        tbl[4]  = '{1'b1, 1'b1, 1'b0, pk(3, 0, 0, 0, 0)}; // streak 1
        tbl[5]  = '{1'b1, 1'b0, 1'b0, pk(3, 0, 0, 0, 0)}; // streak cleared
        tbl[6]  = '{1'b0, 1'b1, 1'b0, pk(3, 0, 0, 0, 0)}; // between ticks ignored
        tbl[7]  = '{1'b1, 1'b1, 1'b0, pk(3, 0, 0, 0, 0)}; // streak 1
        tbl[8]  = '{1'b0, 1'b1, 1'b0, pk(3, 0, 0, 0, 0)}; // between ticks
        tbl[9]  = '{1'b0, 1'b0, 1'b0, pk(3, 0, 0, 0, 0)};
        tbl[10] = '{1'b1, 1'b0, 1'b0, pk(3, 0, 0, 0, 0)}; // streak cleared
        tbl[11] = '{1'b1, 1'b1, 1'b0, pk(3, 0, 0, 0, 0)}; // streak 1
        tbl[12] = '{1'b1, 1'b1, 1'b0, pk(2, 1, 0, 1, 0)}; // confirmed hit
        tbl[13] = '{1'b0, 1'b1, 1'b0, pk(2, 1, 0, 1, 0)};
        tbl[14] = '{1'b1, 1'b0, 1'b0, pk(2, 1, 0, 1, 0)}; // frame 1
        tbl[15] = '{1'b1, 1'b1, 1'b1, pk(2, 1, 0, 1, 0)}; // frame 2, start ignored
        tbl[16] = '{1'b1, 1'b0, 1'b0, pk(2, 1, 0, 1, 0)}; // frame 3
        tbl[17] = '{1'b1, 1'b0, 1'b0, pk(2, 0, 1, 0, 0)}; // frame 4 -> respawn
        tbl[18] = '{1'b0, 1'b0, 1'b0, pk(2, 0, 0, 0, 0)};

        repeat (3) @(posedge clk);
        #1;
        check("reset_values", pk(3, 1, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        for (int i = 0; i < 19; i++) begin
            step(tbl[i].tick, tbl[i].coll, tbl[i].start);
            check($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Second and third hits drain lives to zero, then game over
        step(1, 1, 0); step(1, 1, 0);
        check("hit2_lives1", pk(1, 1, 0, 1, 0));
        repeat (3) step(1, 0, 0);
        step(1, 0, 0);
        check("hit2_respawn", pk(1, 0, 1, 0, 0));
        step(1, 1, 0); step(1, 1, 0);
        check("hit3_lives0", pk(0, 1, 0, 1, 0));
        repeat (3) step(1, 0, 0);
        step(1, 0, 0);
        check("game_over_no_respawn", pk(0, 1, 0, 0, 1));
        step(1, 1, 0);
        check("game_over_holds", pk(0, 1, 0, 0, 1));

        // Start and a colliding tick together in OVER: tick not sampled
        step(1, 1, 1);
        check("over_start_tick", pk(3, 0, 1, 0, 0));
        step(1, 1, 0);
        check("first_streak_no_hit", pk(3, 0, 0, 0, 0));

        // Reach HIT with one life left, then reset asynchronously
        step(1, 1, 0);
        check("hit_a", pk(2, 1, 0, 1, 0));
        repeat (4) step(1, 0, 0);
        step(1, 1, 0); step(1, 1, 0);
        check("hit_lives1", pk(1, 1, 0, 1, 0));
        step(1, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_mid_hit", pk(3, 1, 0, 0, 0));
        step(1, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 0);
            check($sformatf("idle_after_reset%0d", i), pk(3, 1, 0, 0, 0));
        end

        // Randomized play against the rule-level model
        rst_n = 1'b0;
        step(0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            bit t, c, s;
            t = ($urandom_range(0, 1) == 1);
            c = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 29) == 0);
            model_step(t, c, s);
            step(t, c, s);
            check($sformatf("rand%0d", i),
                  pk(m_lives, !m_run, m_resp, m_inhit, m_over));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/collision_life_fsm.md
Name: collision_life_fsm

Overview:
- Consumes the per-row collision bit produced by the 8:1 lane collision mux and turns it into game-level consequences.
- Consequences: confirmed hit, freeze period, life decrement, frog respawn request, game over.
- Sits between the collision mux and the frog position / lane scroll logic. It drives their freeze and respawn controls.
- All sampling is gated by the per-frame tick, so a one-frame sprite-overlap glitch does not kill the frog.

Parameters:
- LIVES_INIT, 3, lives loaded on game start.
- LIVES_WIDTH, 2, width of lives counter; must hold LIVES_INIT.
- CONFIRM_TICKS, 2, consecutive frame ticks with collision high needed to confirm a hit (>=1).
- HIT_FRAMES, 30, frame ticks spent frozen in HIT state (>=1).
- CNT_WIDTH, 6, width of the internal confirm and hit-frame counters; must hold max(CONFIRM_TICKS, HIT_FRAMES).

Ports:
- CLOCK_50  input  1  system clock.
- RESET_InLow  input  1  asynchronous active-low reset.
- CollisionLife_FrameTick_In  input  1  one-cycle pulse per video frame.
- CollisionLife_Collision_In  input  1  collision bit from the lane collision mux (0 when frog is in safe row 0).
- CollisionLife_Start_In  input  1  one-cycle start pulse from debounced button.
- CollisionLife_Lives_Out  output  LIVES_WIDTH  remaining lives.
- CollisionLife_Freeze_Out  output  1  high = frog movement and lane scrolling halted.
- CollisionLife_Respawn_Out  output  1  one-cycle pulse; frog position logic returns frog to start row.
- CollisionLife_Hit_Out  output  1  high while in HIT (drives flash/sound).
- CollisionLife_GameOver_Out  output  1  high in OVER.

Behaviour:
- Clock and reset: one clock, CLOCK_50. Reset is asynchronous and active-low (RESET_InLow).
- All outputs are registered.
- Reset values:
  - state=IDLE
  - Lives=LIVES_INIT
  - Freeze=1
  - Respawn=0, Hit=0, GameOver=0
  - confirm counter=0, hit counter=0
- Reset asserted mid-game returns to these values immediately; no pending respawn pulse survives.
- States:
  - IDLE (00): waiting for start.
  - PLAY (01): game running.
  - HIT (10): frog frozen after a confirmed hit.
  - OVER (11): game ended.
- IDLE:
  - Freeze=1.
  - On Start_In, next cycle: state=PLAY, Lives=LIVES_INIT, Respawn=1 for exactly one cycle, confirm counter=0.
- PLAY:
  - Freeze=0.
  - Collision_In is sampled only on cycles where FrameTick_In=1.
  - Tick with Collision_In=1: confirm counter +1.
  - Tick with Collision_In=0: confirm counter cleared.
  - Hit confirmation: on the tick that brings the count to CONFIRM_TICKS, the next cycle shows state=HIT, Hit=1, Freeze=1, Lives-1 (saturating at 0), confirm counter=0, hit counter=0. Latency is 1 clock from the confirming tick.
  - Collision_In changes between ticks are ignored.
  - Start_In is ignored.
- HIT:
  - Freeze=1, Hit=1.
  - Each frame tick increments the hit counter.
  - On the tick where the count reaches HIT_FRAMES:
    - Lives==0: next state=OVER, Hit=0, GameOver=1.
    - Lives>0: next state=PLAY, Hit=0, Freeze=0, Respawn=1 for one cycle.
  - Collision_In and Start_In are ignored.
- OVER:
  - Freeze=1, GameOver=1, Lives=0.
  - On Start_In, same as from IDLE: Lives reload, Respawn pulse, PLAY, GameOver=0.
- Simultaneous events:
  - Start_In and FrameTick_In in the same cycle in IDLE/OVER: start wins; that tick is not sampled for collision.
  - Collision confirmed on the same tick as Respawn's cycle: not possible, because Respawn is issued on the transition cycle and the confirm counter is zeroed then.
- Respawn_Out is never high for more than one consecutive cycle.
- Counters never wrap:
  - The confirm counter is cleared on hit.
  - The hit counter is cleared on HIT entry.
- Lives never underflow.

Decomposition:
- Shared package collision_pkg holds:
  - state encoding constants ST_IDLE, ST_PLAY, ST_HIT, ST_OVER.
  - default LIVES_INIT, CONFIRM_TICKS, HIT_FRAMES, shared with the score/HUD block.
- One natural sub-module: tick_counter. It is a CNT_WIDTH counter with:
  - clear and tick-enable inputs;
  - a terminal-compare output against a parameterised limit.
- tick_counter is instantiated twice: confirm counter and hit-frame counter.
- State register and output logic stay in collision_life_fsm.

Test Plan:
Bench uses LIVES_INIT=3, CONFIRM_TICKS=2, HIT_FRAMES=4.
1. Reset then Start pulse -> next cycle PLAY: Lives=3, Freeze=0, Respawn=1 for exactly one cycle. Before Start: Freeze=1, GameOver=0.
2. In PLAY, Collision_In=1 for one tick, then 0 on the next tick -> no hit, Lives stays 3. Collision_In high between ticks only -> no hit.
3. Collision_In=1 on two consecutive ticks -> 1 clock after the second tick: Hit=1, Freeze=1, Lives=2. After 4 more ticks: Respawn one-cycle pulse, Freeze=0, state PLAY.
4. Three confirmed hits -> Lives reaches 0. After 4 HIT ticks: GameOver=1, Freeze=1, no Respawn pulse. Start pulse -> Lives=3, Respawn pulse, GameOver=0.
5. RESET_InLow asserted during HIT (Lives=1) -> outputs immediately equal reset values (IDLE, Lives=3, Freeze=1, Hit=0). No Respawn after release until Start.
6. In OVER, Start and FrameTick in the same cycle with Collision_In=1 -> PLAY entered, confirm counter 0. A second consecutive colliding tick alone does not cause a hit.
